// File: rtl/text_ram_writer.sv
// Write-side engine for the text-mode video RAM: decodes a byte stream into glyph writes and cursor moves.
// Optional build macro TEXT_SCROLL_EN: scroll the screen up on row overflow instead of wrapping to row 0.
module text_ram_writer #(
  parameter int         COL_BITS  = 5,
  parameter int         ROW_BITS  = 5,
  parameter logic [7:0] FILL_CHAR = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   char_data,
  input  logic                         char_valid,
  output logic                         char_ready,
  output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
  output logic [7:0]                   ram_din,
  output logic                         ram_we,
  input  logic [7:0]                   ram_dout,
  output logic [ROW_BITS-1:0]          cur_row,
  output logic [COL_BITS-1:0]          cur_col,
  output logic                         busy
);

  localparam int NUM_COLS = 2**COL_BITS;
  localparam int NUM_ROWS = 2**ROW_BITS;
  localparam int AW       = ROW_BITS + COL_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
`ifdef TEXT_SCROLL_EN
    , ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_FILL
`endif
  } state_t;

  state_t              r_state;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic [AW-1:0]       r_addr;
  logic [7:0]          r_din;
  logic                r_we;
  logic                r_ready;
  logic                r_adv;

  logic                w_col_last;
  logic                w_row_last;
  logic [COL_BITS-1:0] w_col_dec;

  assign w_col_last = (r_col == '1);
  assign w_row_last = (r_row == '1);
  assign w_col_dec  = r_col - 1'b1;

`ifdef TEXT_SCROLL_EN
  localparam logic [AW-1:0] ROW1_ADDR     = AW'(NUM_COLS);
  localparam logic [AW-1:0] LAST_COPY_DST = AW'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [AW-1:0] LAST_ROW_ADDR = AW'((NUM_ROWS - 1) * NUM_COLS);

  // NOTE: the copied byte arrives from the RAM during SCROLL_WR itself, too late to register, so it bypasses r_din.
  assign ram_din = (r_state == ST_SCROLL_WR) ? ram_dout : r_din;
`else
  logic [7:0] w_unused_dout;
  assign w_unused_dout = ram_dout;
  assign ram_din       = r_din;
`endif

  // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge cursor and address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
      r_adv   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (char_valid && r_ready) begin
            case (char_data)
              8'h0C: begin
                r_state <= ST_CLEAR;
                r_row   <= '0;
                r_col   <= '0;
                r_addr  <= '0;
                r_din   <= FILL_CHAR;
                r_we    <= 1'b1;
                r_ready <= 1'b0;
              end
              8'h0D: r_col <= '0;
              8'h0A: begin
                r_col <= '0;
                if (!w_row_last) begin
                  r_row <= r_row + 1'b1;
                end else begin
`ifdef TEXT_SCROLL_EN
                  r_state <= ST_SCROLL_RD;
                  r_addr  <= ROW1_ADDR;
                  r_ready <= 1'b0;
`else
                  r_row <= '0;
`endif
                end
              end
              8'h08: begin
                if (r_col != '0) begin
                  r_col   <= w_col_dec;
                  r_state <= ST_WRITE;
                  r_addr  <= {r_row, w_col_dec};
                  r_din   <= FILL_CHAR;
                  r_we    <= 1'b1;
                  r_ready <= 1'b0;
                  r_adv   <= 1'b0;
                end
              end
              default: begin
                r_state <= ST_WRITE;
                r_addr  <= {r_row, r_col};
                r_din   <= char_data;
                r_we    <= 1'b1;
                r_ready <= 1'b0;
                r_adv   <= 1'b1;
              end
            endcase
          end
        end

        // Cursor advance lands only after the write cycle, so overflow can start a scroll.
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          if (r_adv) begin
            if (!w_col_last) begin
              r_col <= r_col + 1'b1;
            end else begin
              r_col <= '0;
              if (!w_row_last) begin
                r_row <= r_row + 1'b1;
              end else begin
`ifdef TEXT_SCROLL_EN
                r_state <= ST_SCROLL_RD;
                r_addr  <= ROW1_ADDR;
                r_ready <= 1'b0;
`else
                r_row <= '0;
`endif
              end
            end
          end
        end

        ST_CLEAR: begin
          if (r_addr == '1) begin
            r_we    <= 1'b0;
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end

`ifdef TEXT_SCROLL_EN
        ST_SCROLL_RD: begin
          r_state <= ST_SCROLL_WR;
          r_addr  <= r_addr - ROW1_ADDR;
          r_we    <= 1'b1;
        end

        ST_SCROLL_WR: begin
          if (r_addr == LAST_COPY_DST) begin
            r_state <= ST_SCROLL_FILL;
            r_addr  <= LAST_ROW_ADDR;
            r_din   <= FILL_CHAR;
          end else begin
            r_state <= ST_SCROLL_RD;
            r_addr  <= r_addr + ROW1_ADDR + 1'b1;
            r_we    <= 1'b0;
          end
        end

        ST_SCROLL_FILL: begin
          if (r_addr == '1) begin
            r_we    <= 1'b0;
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready = r_ready;
  assign ram_addr   = r_addr;
  assign ram_we     = r_we;
  assign cur_row    = r_row;
  assign cur_col    = r_col;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_text_ram_writer.sv
// Scoreboard bench for text_ram_writer: stimulus queues expected RAM writes, a negedge monitor pops and compares.
// Honours TEXT_SCROLL_EN to select the expected row-overflow behaviour.
module tb_text_ram_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic [4:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] exp_q[$];
  bit   [7:0]  shadow [1024];
  logic [7:0]  mem    [1024];
  logic        preload = 1'b0;
  logic        mon_en  = 1'b1;
  int          m_row = 0;
  int          m_col = 0;

  text_ram_writer #(.COL_BITS(5), .ROW_BITS(5), .FILL_CHAR(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; preload fills row r with value r.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i / 32);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (mon_en && reset && ram_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr=%0d din=%h, expected no write", ram_addr, ram_din);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_din} !== e) begin
          n_errors++;
          $display("FAIL ram_write: got addr=%0d din=%h, expected addr=%0d din=%h",
                   ram_addr, ram_din, e[17:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int a, input logic [7:0] d);
    exp_q.push_back({10'(a), d});
    shadow[a] = d;
  endtask

  task automatic model_row_adv();
    if (m_row < 31) begin
      m_row++;
    end else begin
`ifdef TEXT_SCROLL_EN
      for (int src = 32; src < 1024; src++) expect_wr(src - 32, shadow[src]);
      for (int a = 992; a < 1024; a++) expect_wr(a, 8'h00);
`else
      m_row = 0;
`endif
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    char_data  = c;
    char_valid = 1'b1;
    while (!char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: char %h never accepted", c);
    end
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", cyc);
    end
  endtask

  // Queue the expected effect of one character, send it, and check cursor and drain afterwards.
  task automatic put(input logic [7:0] c, output int cyc);
    case (c)
      8'h0C: begin
        for (int a = 0; a < 1024; a++) expect_wr(a, 8'h00);
        m_row = 0;
        m_col = 0;
      end
      8'h0D: m_col = 0;
      8'h0A: begin
        m_col = 0;
        model_row_adv();
      end
      8'h08: begin
        if (m_col != 0) begin
          m_col--;
          expect_wr(m_row * 32 + m_col, 8'h00);
        end
      end
      default: begin
        expect_wr(m_row * 32 + m_col, c);
        if (m_col == 31) begin
          m_col = 0;
          model_row_adv();
        end else begin
          m_col++;
        end
      end
    endcase
    send(c);
    wait_idle(cyc);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("ready_after", 32'(char_ready), 32'd1);
    check("model_row", 32'(cur_row), 32'(m_row));
    check("model_col", 32'(cur_col), 32'(m_col));
  endtask

  initial begin
    int cyc;
    int k;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", 32'(ram_din), 32'd0);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(char_ready), 32'd1);

    // Test 1: 'A' writes addr 0, ready drops for exactly the write cycle
    expect_wr(0, 8'h41);
    send(8'h41);
    @(negedge clk);
    check("t1_we", 32'(ram_we), 32'd1);
    check("t1_ready_low", 32'(char_ready), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_ready_high", 32'(char_ready), 32'd1);
    check("t1_we_off", 32'(ram_we), 32'd0);
    check("t1_row", 32'(cur_row), 32'd0);
    check("t1_col", 32'(cur_col), 32'd1);
    check("t1_drain", 32'(exp_q.size()), 32'd0);
    m_col = 1;

    // CR: no write, no busy
    put(8'h0D, cyc);
    check("cr_cycles", 32'(cyc), 32'd0);
    check("cr_col", 32'(cur_col), 32'd0);

    // Test 2: reach (3,31), then 'B' wraps to (4,0)
    for (int i = 0; i < 3; i++) put(8'h0A, cyc);
    for (int i = 0; i < 31; i++) put(8'(8'h50 + i), cyc);
    check("t2_pre_row", 32'(cur_row), 32'd3);
    check("t2_pre_col", 32'(cur_col), 32'd31);
    put(8'h42, cyc);
    check("t2_write_cycles", 32'(cyc), 32'd1);
    check("t2_row", 32'(cur_row), 32'd4);
    check("t2_col", 32'(cur_col), 32'd0);

    // Test 3: form feed clears all 1024 cells
    put(8'h0C, cyc);
    check("t3_busy_cycles", 32'(cyc), 32'd1024);
    check("t3_row", 32'(cur_row), 32'd0);
    check("t3_col", 32'(cur_col), 32'd0);

    // Test 4: backspace at col 0 is a no-op; at col 5 fills col 4
    put(8'h0A, cyc);
    put(8'h0A, cyc);
    put(8'h08, cyc);
    check("t4_noop_cycles", 32'(cyc), 32'd0);
    check("t4_noop_row", 32'(cur_row), 32'd2);
    check("t4_noop_col", 32'(cur_col), 32'd0);
    for (int i = 0; i < 5; i++) put(8'(8'h61 + i), cyc);
    put(8'h08, cyc);
    check("t4_bs_cycles", 32'(cyc), 32'd1);
    check("t4_bs_row", 32'(cur_row), 32'd2);
    check("t4_bs_col", 32'(cur_col), 32'd4);

    // Test 5: LF at (31,7)
    put(8'h0D, cyc);
    for (int i = 0; i < 29; i++) put(8'h0A, cyc);
    for (int i = 0; i < 7; i++) put(8'(8'h30 + i), cyc);
    check("t5_pre_row", 32'(cur_row), 32'd31);
    check("t5_pre_col", 32'(cur_col), 32'd7);
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = 8'(i / 32);
    put(8'h0A, cyc);
`ifdef TEXT_SCROLL_EN
    check("t5_busy_cycles", 32'(cyc), 32'd2016);
    check("t5_row", 32'(cur_row), 32'd31);
    check("t5_col", 32'(cur_col), 32'd0);
    for (int i = 0; i < 1024; i++)
      check("t5_ram_cell", 32'(mem[i]), (i / 32 < 31) ? 32'(i / 32 + 1) : 32'd0);
`else
    check("t5_busy_cycles", 32'(cyc), 32'd0);
    check("t5_row", 32'(cur_row), 32'd0);
    check("t5_col", 32'(cur_col), 32'd0);
    check("t5_ram_untouched", 32'(mem[31 * 32 + 3]), 32'd31);
`endif

    // Test 6: reset dropped while CLEAR is at cell 100
    put(8'h0A, cyc);
    mon_en = 1'b0;
    send(8'h0C);
    k = 0;
    while (!(ram_we && ram_addr == 10'd100) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t6_reached_100", 32'(ram_addr), 32'd100);
    reset = 1'b0;
    @(negedge clk);
    check("t6_we", 32'(ram_we), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(char_ready), 32'd0);
    check("t6_row", 32'(cur_row), 32'd0);
    check("t6_col", 32'(cur_col), 32'd0);
    check("t6_addr", 32'(ram_addr), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_ready_back", 32'(char_ready), 32'd1);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_no_write", 32'(ram_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
